// File: rtl/reset_release_ctrl.sv
// Reset release sequencer: asserts rst_out_n asynchronously, then releases each
// bit synchronously in index order after a synchroniser and a hold-off.
module reset_release_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int NUM_OUT     = 3,
   parameter int STAGGER     = 4
) (
   input  logic               clk,
   input  logic               async_n,
   input  logic               sw_rst_req,
   output logic [NUM_OUT-1:0] rst_out_n,
   output logic               ready,
   output logic [2:0]         state
);

   localparam int TOP = HOLD_CYCLES + (NUM_OUT - 1) * STAGGER;
   localparam int CW  = $clog2(TOP + 1);

   localparam logic [2:0] ST_RST     = 3'd0;
   localparam logic [2:0] ST_SYNC    = 3'd1;
   localparam logic [2:0] ST_HOLD    = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   logic [SYNC_STAGES-1:0] chain;
   logic                   sync_q;
   logic                   sync_pre;
   logic [2:0]             state_q;
   logic [CW-1:0]          cnt;
   logic [NUM_OUT-1:0]     rst_q;
   logic                   ready_q;

   always_ff @(posedge clk or negedge async_n) begin
      if (!async_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // The SYNC exit samples the stage feeding sync_q so HOLD starts on the edge
   // sync_q rises; counting in HOLD/RELEASE is then interlocked on sync_q itself.
   assign sync_pre = chain[SYNC_STAGES-2];
   assign sync_q   = chain[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge async_n) begin
      if (!async_n) begin
         state_q <= ST_RST;
         cnt     <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RST: begin
               state_q <= ST_SYNC;
               cnt     <= '0;
            end
            ST_SYNC: begin
               cnt <= '0;
               if (sync_pre) begin
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (sync_q) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(HOLD_CYCLES - 1)) begin
                     rst_q[0] <= 1'b1;
                     if (NUM_OUT == 1) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                     end else begin
                        state_q <= ST_RELEASE;
                     end
                  end
               end
            end
            ST_RELEASE: begin
               if (sync_q) begin
                  cnt <= cnt + 1'b1;
                  for (int i = 1; i < NUM_OUT; i++) begin
                     if (int'(cnt) == HOLD_CYCLES + i * STAGGER - 1) begin
                        rst_q[i] <= 1'b1;
                     end
                  end
                  if (int'(cnt) == TOP - 1) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // Software restart reuses the already-synchronised release.
               if (sw_rst_req) begin
                  state_q <= ST_HOLD;
                  cnt     <= '0;
                  rst_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_RST;
               cnt     <= '0;
               rst_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign rst_out_n = rst_q;
   assign ready     = ready_q;
   assign state     = state_q;

endmodule
